// File: rtl/lot_access_controller.sv
// ---------------------------------------------------------------------------
// lot_access_controller
//
// Controls the shared single lane of a car park. Entry and exit gates take
// turns on the lane: a gate opens on request, the FSM waits for the photo-sensor
// "done" pulse, updates the car count and returns to IDLE. When both sides
// want the lane at the same time, grants alternate between them.
//
// Optional feature (macro LOT_GATE_TIMEOUT_EN): a 16-bit gate timer closes a
// gate that has stayed open GATE_TIMEOUT cycles without a done pulse and
// pulses timeout_err. Without the macro the timer is absent, a gate waits
// indefinitely for its done pulse and timeout_err is tied low.
//
// Parameters
//   CAPACITY      maximum cars admitted (1..31)
//   GATE_TIMEOUT  cycles a gate may stay open without completion (1..65535)
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   enter_req    pulse: car waiting at the entry gate
//   exit_req     pulse: car waiting at the exit gate
//   enter_done   pulse: car fully through the entry gate
//   exit_done    pulse: car fully through the exit gate
//   gate_in      entry gate open command (registered)
//   gate_out     exit gate open command (registered)
//   occupancy    current car count (registered)
//   full         occupancy == CAPACITY
//   empty        occupancy == 0
//   timeout_err  one-cycle pulse when a gate closes on timeout
// ---------------------------------------------------------------------------
module lot_access_controller #(
  parameter int CAPACITY     = 25,
  parameter int GATE_TIMEOUT = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic       enter_done,
  input  logic       exit_done,
  output logic       gate_in,
  output logic       gate_out,
  output logic [4:0] occupancy,
  output logic       full,
  output logic       empty,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT} state_t;

  localparam logic [4:0] CAP = 5'(CAPACITY);

  state_t state;
  logic   pend_in;
  logic   pend_out;
  logic   last_in;     // last grant went to the entry side

  logic   want_in;
  logic   want_out;
  logic   elig_in;
  logic   elig_out;
  logic   grant_in;
  logic   grant_out;
  logic   expired;

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == 5'd0);

  // A request pulse in the grant cycle counts as already pending, so it is
  // absorbed by the grant instead of leaving a stale flag behind.
  assign want_in  = pend_in  | enter_req;
  assign want_out = pend_out | exit_req;

  assign elig_in  = (state == IDLE) & want_in  & ~full;
  assign elig_out = (state == IDLE) & want_out & ~empty;

  // Round-robin: on contention the side not granted last wins.
  assign grant_out = elig_out & (~elig_in | last_in);
  assign grant_in  = elig_in & ~grant_out;

`ifdef LOT_GATE_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(GATE_TIMEOUT - 1);
  logic [15:0] timer;
  assign expired = (timer == TIMER_LAST);
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gate_in   <= 1'b0;
      gate_out  <= 1'b0;
      occupancy <= 5'd0;
      pend_in   <= 1'b0;
      pend_out  <= 1'b0;
      last_in   <= 1'b1;
`ifdef LOT_GATE_TIMEOUT_EN
      timer       <= 16'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      pend_in  <= want_in  & ~grant_in;
      pend_out <= want_out & ~grant_out;
`ifdef LOT_GATE_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_out) begin
            state    <= OPEN_OUT;
            gate_out <= 1'b1;
            last_in  <= 1'b0;
`ifdef LOT_GATE_TIMEOUT_EN
            timer    <= 16'd0;
`endif
          end else if (grant_in) begin
            state   <= OPEN_IN;
            gate_in <= 1'b1;
            last_in <= 1'b1;
`ifdef LOT_GATE_TIMEOUT_EN
            timer   <= 16'd0;
`endif
          end
        end

        OPEN_IN: begin
          // A done pulse in the expiry cycle wins over the timeout.
          if (enter_done) begin
            if (!full) occupancy <= occupancy + 5'd1;
            gate_in <= 1'b0;
            state   <= IDLE;
          end else if (expired) begin
            gate_in <= 1'b0;
            state   <= IDLE;
`ifdef LOT_GATE_TIMEOUT_EN
            timeout_err <= 1'b1;
`endif
          end
`ifdef LOT_GATE_TIMEOUT_EN
          timer <= timer + 16'd1;
`endif
        end

        OPEN_OUT: begin
          if (exit_done) begin
            if (!empty) occupancy <= occupancy - 5'd1;
            gate_out <= 1'b0;
            state    <= IDLE;
          end else if (expired) begin
            gate_out <= 1'b0;
            state    <= IDLE;
`ifdef LOT_GATE_TIMEOUT_EN
            timeout_err <= 1'b1;
`endif
          end
`ifdef LOT_GATE_TIMEOUT_EN
          timer <= timer + 16'd1;
`endif
        end

        default: begin
          state    <= IDLE;
          gate_in  <= 1'b0;
          gate_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lot_access_controller.sv
// ---------------------------------------------------------------------------
// tb_lot_access_controller
//
// Directed bench for lot_access_controller. Two instances share the stimulus:
// dut_a (CAPACITY=25, GATE_TIMEOUT=8) for the general scenarios and dut_b
// (CAPACITY=2) for the full-lot scenario. Outputs are sampled 1 time unit
// after each rising edge; inputs change at that point too.
// ---------------------------------------------------------------------------
module tb_lot_access_controller;

  logic clk = 1'b0;
  logic reset;
  logic enter_req, exit_req, enter_done, exit_done;

  logic       gate_in_a, gate_out_a, full_a, empty_a, terr_a;
  logic [4:0] occ_a;
  logic       gate_in_b, gate_out_b, full_b, empty_b, terr_b;
  logic [4:0] occ_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lot_access_controller #(.CAPACITY(25), .GATE_TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset),
    .enter_req(enter_req), .exit_req(exit_req),
    .enter_done(enter_done), .exit_done(exit_done),
    .gate_in(gate_in_a), .gate_out(gate_out_a), .occupancy(occ_a),
    .full(full_a), .empty(empty_a), .timeout_err(terr_a)
  );

  lot_access_controller #(.CAPACITY(2), .GATE_TIMEOUT(250)) dut_b (
    .clk(clk), .reset(reset),
    .enter_req(enter_req), .exit_req(exit_req),
    .enter_done(enter_done), .exit_done(exit_done),
    .gate_in(gate_in_b), .gate_out(gate_out_b), .occupancy(occ_b),
    .full(full_b), .empty(empty_b), .timeout_err(terr_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given input pulses, then inputs return low.
  task automatic cyc(input logic er, input logic xr, input logic ed, input logic xd);
    enter_req  = er;
    exit_req   = xr;
    enter_done = ed;
    exit_done  = xd;
    @(posedge clk);
    #1;
    enter_req  = 1'b0;
    exit_req   = 1'b0;
    enter_done = 1'b0;
    exit_done  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic admit_one();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    enter_req = 1'b0; exit_req = 1'b0; enter_done = 1'b0; exit_done = 1'b0;

    // ---- Reset state and single entry ----
    do_reset();
    check("rst_gate_in",  16'(gate_in_a),  16'd0);
    check("rst_gate_out", 16'(gate_out_a), 16'd0);
    check("rst_occ",      16'(occ_a),      16'd0);
    check("rst_empty",    16'(empty_a),    16'd1);
    check("rst_full",     16'(full_a),     16'd0);
    check("rst_terr",     16'(terr_a),     16'd0);
    check("rst_b_empty",  16'(empty_b),    16'd1);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("enter_gate_in",  16'(gate_in_a),  16'd1);
    check("enter_gate_out", 16'(gate_out_a), 16'd0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("enter_hold",     16'(gate_in_a),  16'd1);
    check("enter_hold_occ", 16'(occ_a),      16'd0);
    // done lands in what would be the expiry cycle: count wins, no error
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("done_gate_in", 16'(gate_in_a), 16'd0);
    check("done_occ",     16'(occ_a),     16'd1);
    check("done_empty",   16'(empty_a),   16'd0);
    check("done_terr",    16'(terr_a),    16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("absorbed_req", 16'(gate_in_a), 16'd0);

    // ---- Round-robin contention at occupancy 3 ----
    do_reset();
    repeat (3) admit_one();
    check("rr_occ3", 16'(occ_a), 16'd3);
    cyc(1'b1, 1'b1, 1'b0, 0);
    check("rr1_gate_out", 16'(gate_out_a), 16'd1);
    check("rr1_gate_in",  16'(gate_in_a),  16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rr1_exit_occ", 16'(occ_a),      16'd2);
    check("rr1_closed",   16'(gate_out_a), 16'd0);
    check("rr1_in_wait",  16'(gate_in_a),  16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rr1_gate_in_next", 16'(gate_in_a), 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("rr1_final_occ", 16'(occ_a), 16'd3);
    // last grant was entry; give exit one turn, then contend again
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rr2_occ", 16'(occ_a), 16'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("rr2_gate_in",  16'(gate_in_a),  16'd1);
    check("rr2_gate_out", 16'(gate_out_a), 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("rr2_occ_in", 16'(occ_a), 16'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rr2_pending_out", 16'(gate_out_a), 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rr2_occ_out", 16'(occ_a), 16'd2);

    // ---- Full lot (dut_b, CAPACITY=2) ----
    do_reset();
    repeat (2) admit_one();
    check("full_occ", 16'(occ_b),  16'd2);
    check("full_flag", 16'(full_b), 16'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("full_no_gate", 16'(gate_in_b), 16'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_still_no_gate", 16'(gate_in_b), 16'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("full_gate_out", 16'(gate_out_b), 16'd1);
    check("full_gate_in0", 16'(gate_in_b),  16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("full_exit_occ",  16'(occ_b),      16'd1);
    check("full_exit_flag", 16'(full_b),     16'd0);
    check("full_exit_gate", 16'(gate_out_b), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_pending_in", 16'(gate_in_b), 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_refill_occ",  16'(occ_b),  16'd2);
    check("full_refill_flag", 16'(full_b), 16'd1);

    // ---- Gate timeout (GATE_TIMEOUT=8) ----
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo_open", 16'(gate_in_a), 16'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("tmo_held", 16'(gate_in_a), 16'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef LOT_GATE_TIMEOUT_EN
    check("tmo_closed", 16'(gate_in_a), 16'd0);
    check("tmo_err",    16'(terr_a),    16'd1);
    check("tmo_occ",    16'(occ_a),     16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("tmo_err_pulse", 16'(terr_a), 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("tmo_late_done", 16'(occ_a), 16'd0);
`else
    check("notmo_open", 16'(gate_in_a), 16'd1);
    check("notmo_err",  16'(terr_a),    16'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("notmo_done_occ",  16'(occ_a),     16'd1);
    check("notmo_done_gate", 16'(gate_in_a), 16'd0);
`endif

    // ---- Exit request on empty lot, stray done while IDLE ----
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("empty_no_gate_out", 16'(gate_out_a), 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("stray_done_occ",  16'(occ_a),      16'd0);
    check("stray_done_gin",  16'(gate_in_a),  16'd0);
    check("stray_done_gout", 16'(gate_out_a), 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("empty_entry_first", 16'(gate_in_a),  16'd1);
    check("empty_entry_gout",  16'(gate_out_a), 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("empty_entry_occ", 16'(occ_a), 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("pend_out_kept", 16'(gate_out_a), 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("pend_out_exit_occ", 16'(occ_a),   16'd0);
    check("pend_out_empty",    16'(empty_a), 16'd1);

    // ---- Reset while exit gate open, with exit_done in the same cycle ----
    do_reset();
    repeat (2) admit_one();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_open_gate_out", 16'(gate_out_a), 16'd1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    check("rst_open_gout",  16'(gate_out_a), 16'd0);
    check("rst_open_gin",   16'(gate_in_a),  16'd0);
    check("rst_open_occ",   16'(occ_a),      16'd0);
    check("rst_open_empty", 16'(empty_a),    16'd1);
    check("rst_open_terr",  16'(terr_a),     16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_open_idle_gout", 16'(gate_out_a), 16'd0);
    check("rst_open_idle_occ",  16'(occ_a),      16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lot_access_controller.md
LOT_ACCESS_CONTROLLER -- requirements
Module: lot_access_controller

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 25, maximum cars admitted (1..31).
REQ-002 The block SHALL have parameter GATE_TIMEOUT, default 250, number of cycles a gate may stay open without completion (1..65535).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enter_req  input  1  single-cycle pulse: car waiting at the entry gate.
REQ-006 The block SHALL have port exit_req  input  1  single-cycle pulse: car waiting at the exit gate.
REQ-007 The block SHALL have port enter_done  input  1  single-cycle pulse from the entry photo-sensor decoder: car fully passed.
REQ-008 The block SHALL have port exit_done  input  1  single-cycle pulse from the exit photo-sensor decoder: car fully passed.
REQ-009 The block SHALL have port gate_in  output  1  entry gate open command, registered.
REQ-010 The block SHALL have port gate_out  output  1  exit gate open command, registered.
REQ-011 The block SHALL have port occupancy  output  5  current car count, registered.
REQ-012 The block SHALL have port full  output  1  high when occupancy == CAPACITY.
REQ-013 The block SHALL have port empty  output  1  high when occupancy == 0.
REQ-014 The block SHALL have port timeout_err  output  1  single-cycle pulse when a gate closes on timeout.

Function
REQ-015 The shared lane SHALL be controlled by FSM states IDLE, OPEN_IN and OPEN_OUT, and at most one of gate_in and gate_out SHALL be high in any cycle.
REQ-016 Each request pulse SHALL set a pending flag (pend_in, pend_out), which SHALL be cleared only when that side is granted.
REQ-017 In IDLE, entry SHALL be eligible when (pend_in | enter_req) & ~full, and exit SHALL be eligible when (pend_out | exit_req) & ~empty.
REQ-018 When exactly one side is eligible in IDLE, the FSM SHALL move to its OPEN state and assert the matching gate output from the next cycle (one-cycle latency from the req pulse).
REQ-019 When both sides are eligible in IDLE, grant SHALL be round-robin: the side not granted last wins, and after reset exit wins first.
REQ-020 A request pulse arriving in the same cycle its side is granted SHALL be absorbed into that grant and SHALL leave no pending flag.
REQ-021 In OPEN_IN, enter_done SHALL increment occupancy, deassert gate_in and return the FSM to IDLE, all in the next cycle.
REQ-022 In OPEN_OUT, exit_done SHALL decrement occupancy, deassert gate_out and return the FSM to IDLE, all in the next cycle.
REQ-023 A done pulse for the side whose gate is not open SHALL be ignored with no count change.
REQ-024 Occupancy SHALL saturate at CAPACITY and at 0, and SHALL never wrap.
REQ-025 An entry request while full SHALL remain pending and SHALL be granted once occupancy drops below CAPACITY.
REQ-026 An exit request while empty SHALL remain pending.
REQ-027 A 16-bit gate timer SHALL clear on entering an OPEN state and SHALL increment each cycle while in an OPEN state.
REQ-028 Timeout behaviour SHALL be as defined under Configuration.
REQ-029 full and empty SHALL be combinational decodes of the registered occupancy.

Reset
REQ-030 Asserting reset SHALL, at the next clock edge: set FSM to IDLE; gate_in=0; gate_out=0; occupancy=0; pend_in=0; pend_out=0; timer=0; timeout_err=0; last-grant = entry (so exit wins first).
REQ-031 Reset during an OPEN state SHALL close the gate with no count change, and any done pulse in the reset cycle SHALL be ignored.

Configuration
REQ-032 The timeout feature SHALL be compiled in or out by macro LOT_GATE_TIMEOUT_EN.
REQ-033 With LOT_GATE_TIMEOUT_EN defined, the timer reaching GATE_TIMEOUT-1 with no done pulse SHALL close the gate, return the FSM to IDLE, pulse timeout_err for one cycle and leave occupancy unchanged.
REQ-034 With LOT_GATE_TIMEOUT_EN defined, a done pulse in the expiry cycle SHALL take precedence: the count updates and no error is flagged.
REQ-035 Without LOT_GATE_TIMEOUT_EN, the timer SHALL be absent, the gate SHALL stay open until its done pulse, and timeout_err SHALL be tied 0.

Verification
REQ-036 The bench SHALL cover: reset, then enter_req at cycle 2 -> gate_in=1 from cycle 3; enter_done at cycle 10 -> cycle 11 gate_in=0, occupancy=1, empty=0.
REQ-037 The bench SHALL cover: occupancy=3, enter_req and exit_req in the same cycle after reset -> gate_out granted first; after exit_done -> gate_in granted next; final occupancy=3.
REQ-038 The bench SHALL cover: CAPACITY=2 filled to 2 (full=1), enter_req -> no gate_in; then exit_req and exit_done -> occupancy=1 and gate_in asserts the cycle after gate_out closes.
REQ-039 The bench SHALL cover (LOT_GATE_TIMEOUT_EN, GATE_TIMEOUT=8): enter_req with no enter_done -> gate_in high 8 cycles, then timeout_err pulses once and occupancy stays 0.
REQ-040 The bench SHALL cover: empty lot, exit_req, and enter_done while IDLE -> no gate, occupancy stays 0, pend_out stays set.
REQ-041 The bench SHALL cover: reset asserted while gate_out=1 with exit_done in the same cycle -> next cycle all outputs at reset values, occupancy=0.
